// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier that drives an external combinational Adder.
// Optional o_overflow output is enabled by defining MULTIPLIER_OVERFLOW_EN.
module shift_add_multiplier #(
    parameter int unsigned BITS = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [BITS-1:0]     i_multiplicand,
    input  logic [BITS-1:0]     i_multiplier,
    output logic [BITS-1:0]     o_augend,
    output logic [BITS-1:0]     o_addend,
    input  logic [BITS-1:0]     i_sum,
    input  logic                i_carry,
    output logic                o_busy,
    output logic                o_done,
`ifdef MULTIPLIER_OVERFLOW_EN
    output logic                o_overflow,
`endif
    output logic [2*BITS-1:0]   o_product
);

    localparam int unsigned    CW   = $clog2(BITS) + 1;
    localparam logic [CW-1:0]  LAST = CW'(BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BITS-1:0] acc_a;
    logic [BITS-1:0] reg_q;
    logic [BITS-1:0] reg_m;
    logic [CW-1:0]   count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
        o_done = (state == DONE);
    end

    // Adder operands come only from registers, so no loop forms through the Adder.
    assign o_augend = acc_a;
    assign o_addend = reg_q[0] ? reg_m : '0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_a     <= '0;
            reg_q     <= '0;
            reg_m     <= '0;
            count     <= '0;
            o_product <= '0;
`ifdef MULTIPLIER_OVERFLOW_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        reg_m     <= i_multiplicand;
                        reg_q     <= i_multiplier;
                        acc_a     <= '0;
                        count     <= '0;
                        o_product <= '0;
`ifdef MULTIPLIER_OVERFLOW_EN
                        o_overflow <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    acc_a <= {i_carry, i_sum[BITS-1:1]};
                    reg_q <= {i_sum[0], reg_q[BITS-1:1]};
                    count <= count + CW'(1);
                    // Capture the final shifted {A,Q} so the product is already valid in DONE.
                    if (count == LAST) begin
                        o_product <= {i_carry, i_sum, reg_q[BITS-1:1]};
`ifdef MULTIPLIER_OVERFLOW_EN
                        o_overflow <= ({i_carry, i_sum[BITS-1:1]} != '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed steps plus an exhaustive
// back-to-back sweep, with products scoreboarded and compared on every o_done pulse.
module tb_shift_add_multiplier;

    localparam int unsigned BITS = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [BITS-1:0]     mcand = '0;
    logic [BITS-1:0]     mplier = '0;
    logic [BITS-1:0]     augend;
    logic [BITS-1:0]     addend;
    logic [BITS-1:0]     sum;
    logic                carry;
    logic                busy;
    logic                done;
    logic [2*BITS-1:0]   product;
`ifdef MULTIPLIER_OVERFLOW_EN
    logic                overflow;
`endif

    logic [BITS:0]       add_res;
    logic [2*BITS-1:0]   sb[$];
    int                  n_checks = 0;
    int                  n_fail = 0;
    int                  done_count = 0;

    shift_add_multiplier #(.BITS(BITS)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .o_augend       (augend),
        .o_addend       (addend),
        .i_sum          (sum),
        .i_carry        (carry),
        .o_busy         (busy),
        .o_done         (done),
`ifdef MULTIPLIER_OVERFLOW_EN
        .o_overflow     (overflow),
`endif
        .o_product      (product)
    );

    // Stand-in for the shared Adder that sits beside the multiplier.
    assign add_res = {1'b0, augend} + {1'b0, addend};
    assign sum     = add_res[BITS-1:0];
    assign carry   = add_res[BITS];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            logic [2*BITS-1:0] exp_p;
            done_count++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_done observed=%0d expected=%0d", sb.size(), 1);
            end
            if (sb.size() != 0) begin
                exp_p = sb.pop_front();
                check("product", 64'(product), 64'(exp_p));
`ifdef MULTIPLIER_OVERFLOW_EN
                check("overflow", 64'(overflow), 64'(exp_p[2*BITS-1:BITS] != '0));
`endif
            end
        end
    end

    // Start one multiplication and check busy/done cycle by cycle.
    task automatic mult_timed(input int x, input int y);
        @(negedge clk);
        start  = 1'b1;
        mcand  = BITS'(x);
        mplier = BITS'(y);
        sb.push_back((2*BITS)'(x * y));
        @(posedge clk);
        for (int j = 0; j <= int'(BITS); j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
            check("busy_run", 64'(busy), 64'(1));
            check("done_timing", 64'(done), 64'(j == int'(BITS)));
        end
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'(0));
        check("done_idle", 64'(done), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout observed=%0d expected=%0d", done_count, sb.size());
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int dc;

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        check("reset_augend", 64'(augend), 64'(0));
`ifdef MULTIPLIER_OVERFLOW_EN
        check("reset_overflow", 64'(overflow), 64'(0));
`endif
        rst = 1'b0;

        mult_timed(3, 5);

        mult_timed(15, 15);
        repeat (10) begin
            @(negedge clk);
            check("product_hold", 64'(product), 64'(225));
`ifdef MULTIPLIER_OVERFLOW_EN
            check("overflow_hold", 64'(overflow), 64'(1));
`endif
        end

        mult_timed(0, 9);
        mult_timed(9, 0);

        // A start pulse during RUN must be ignored.
        dc = done_count;
        @(negedge clk);
        start = 1'b1; mcand = 6; mplier = 6;
        sb.push_back(36);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; mcand = 7; mplier = 2;
        @(negedge clk);
        start = 1'b0;
        repeat (BITS + 6) @(negedge clk);
        check("single_done", 64'(done_count - dc), 64'(1));

        // Reset in the second RUN cycle discards the partial product.
        dc = done_count;
        @(negedge clk);
        start = 1'b1; mcand = 13; mplier = 11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_product", 64'(product), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        rst = 1'b0;
        repeat (BITS + 2) @(negedge clk);
        check("abort_no_done", 64'(done_count - dc), 64'(0));
        mult_timed(13, 11);

        // Exhaustive sweep with start held high: each new start lands in the IDLE after DONE.
        dc = done_count;
        @(negedge clk);
        start = 1'b1;
        for (int x = 0; x < (1 << BITS); x++) begin
            for (int y = 0; y < (1 << BITS); y++) begin
                mcand  = BITS'(x);
                mplier = BITS'(y);
                sb.push_back((2*BITS)'(x * y));
                check("sweep_idle", 64'(busy), 64'(0));
                repeat (BITS + 2) @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("sweep_done_count", 64'(done_count - dc), 64'(1 << (2 * BITS)));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
